// File: rtl/median_filter_stream.sv
// Streaming 3x3 median filter over raster frames: two line buffers feed a 3x3 window and a
// two-stage compare-exchange median. Define MEDIAN_BORDER_REPLICATE_EN for edge-clamped borders.
module median_filter_stream #(
    parameter int PIXEL_W = 8,
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bypass,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PIXEL_W-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [PIXEL_W-1:0] m_data,
    output logic               m_last,
    output logic               done
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H + 2);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(IMG_H + 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    function automatic logic [PIXEL_W-1:0] min2(input logic [PIXEL_W-1:0] a, input logic [PIXEL_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [PIXEL_W-1:0] max2(input logic [PIXEL_W-1:0] a, input logic [PIXEL_W-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [PIXEL_W-1:0] med3(input logic [PIXEL_W-1:0] a, input logic [PIXEL_W-1:0] b,
                                                input logic [PIXEL_W-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    state_t             state;
    logic [ROW_W-1:0]   row_reg;
    logic [COL_W-1:0]   col_reg, col_next, rd_addr;
    logic               bypass_reg;
    logic               adv, take, flush_step, step, out_last_fire;
    logic               v0_reg, v1_reg;
    logic [3:0]         edge_reg;
    logic               last_reg, last1_reg, pass1_reg;
    logic [PIXEL_W-1:0] ctr1_reg;
    logic [PIXEL_W-1:0] lb_mid, lb_top;
    logic [PIXEL_W-1:0] col_in [3];
    logic [PIXEL_W-1:0] win [3][3];
    logic [PIXEL_W-1:0] cw [3][3];
    logic [PIXEL_W-1:0] med_lo, med_md, med_hi, median;
    logic [ROW_W-1:0]   ctr_row;
    logic [COL_W-1:0]   ctr_col;

    assign adv           = !m_valid || m_ready;
    assign s_ready       = !reset && adv && (state != FLUSH);
    assign take          = s_valid && s_ready;
    // Flush steps run from (IMG_H,0) through (IMG_H+1,0) inclusive.
    assign flush_step    = adv && (state == FLUSH) && !(row_reg == ROW_END && col_reg != '0);
    assign step          = take || flush_step;
    assign out_last_fire = m_valid && m_ready && m_last;

    // The registered line-buffer read is prefetched for the column of the next step.
    assign col_next = (col_reg == COL_LAST) ? '0 : col_reg + COL_W'(1);
    assign rd_addr  = step ? col_next : col_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic [PIXEL_W-1:0] mem [IMG_W];
            logic [PIXEL_W-1:0] rd_reg;
            logic [PIXEL_W-1:0] wr_data;
            assign wr_data = (gi == 0) ? s_data : lb_mid;
            always_ff @(posedge clk) begin
                if (step)
                    mem[col_reg] <= wr_data;
                rd_reg <= mem[rd_addr];
            end
        end
    endgenerate

    assign lb_mid    = g_line[0].rd_reg;
    assign lb_top    = g_line[1].rd_reg;
    assign col_in[0] = lb_top;
    assign col_in[1] = lb_mid;
    assign col_in[2] = s_data;

    // After the step at (row,col) the window centre is raster index step-IMG_W-1.
    assign ctr_row = (col_reg == '0) ? row_reg - ROW_W'(2) : row_reg - ROW_W'(1);
    assign ctr_col = (col_reg == '0) ? COL_LAST : col_reg - COL_W'(1);

    always_ff @(posedge clk) begin
        if (step) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
                win[r][2] <= col_in[r];
            end
            edge_reg <= {ctr_col == COL_LAST, ctr_col == '0, ctr_row == ROW_LAST, ctr_row == '0};
            last_reg <= (ctr_row == ROW_LAST) && (ctr_col == COL_LAST);
        end
    end

    always_comb begin
        logic [1:0] rsel [3];
        logic [1:0] csel [3];
        for (int i = 0; i < 3; i++) begin
            rsel[i] = 2'(i);
            csel[i] = 2'(i);
        end
`ifdef MEDIAN_BORDER_REPLICATE_EN
        if (edge_reg[0]) rsel[0] = 2'd1;
        if (edge_reg[1]) rsel[2] = 2'd1;
        if (edge_reg[2]) csel[0] = 2'd1;
        if (edge_reg[3]) csel[2] = 2'd1;
`endif
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                cw[r][c] = win[rsel[r]][csel[c]];
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sort
            logic [PIXEL_W-1:0] lo_reg, md_reg, hi_reg;
            always_ff @(posedge clk) begin
                if (adv && v0_reg) begin
                    lo_reg <= min2(min2(cw[gi][0], cw[gi][1]), cw[gi][2]);
                    md_reg <= med3(cw[gi][0], cw[gi][1], cw[gi][2]);
                    hi_reg <= max2(max2(cw[gi][0], cw[gi][1]), cw[gi][2]);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (adv && v0_reg) begin
            ctr1_reg  <= win[1][1];
            last1_reg <= last_reg;
`ifdef MEDIAN_BORDER_REPLICATE_EN
            pass1_reg <= bypass_reg;
`else
            pass1_reg <= bypass_reg || (|edge_reg);
`endif
        end
    end

    // Median of 9 = median(max of row minima, median of row medians, min of row maxima).
    assign med_lo = max2(max2(g_sort[0].lo_reg, g_sort[1].lo_reg), g_sort[2].lo_reg);
    assign med_md = med3(g_sort[0].md_reg, g_sort[1].md_reg, g_sort[2].md_reg);
    assign med_hi = min2(min2(g_sort[0].hi_reg, g_sort[1].hi_reg), g_sort[2].hi_reg);
    assign median = med3(med_lo, med_md, med_hi);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            row_reg    <= '0;
            col_reg    <= '0;
            bypass_reg <= 1'b0;
            v0_reg     <= 1'b0;
            v1_reg     <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= out_last_fire;
            if (step) begin
                col_reg <= col_next;
                if (col_reg == COL_LAST)
                    row_reg <= row_reg + ROW_W'(1);
            end
            if (adv) begin
                v0_reg  <= step && (state == RUN || state == FLUSH);
                v1_reg  <= v0_reg;
                m_valid <= v1_reg;
                m_last  <= v1_reg && last1_reg;
                if (v1_reg)
                    m_data <= pass1_reg ? ctr1_reg : median;
            end
            case (state)
                IDLE: if (step) begin
                    state      <= FILL;
                    bypass_reg <= bypass;
                end
                FILL: if (step && row_reg == ROW_W'(1) && col_reg == '0)
                    state <= RUN;
                RUN: if (step && row_reg == ROW_LAST && col_reg == COL_LAST)
                    state <= FLUSH;
                FLUSH: if (out_last_fire) begin
                    state   <= IDLE;
                    row_reg <= '0;
                    col_reg <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_median_filter_stream.sv
// Bench for median_filter_stream on an 8x6 frame: a per-pixel reference model feeds an expected
// queue checked on every output handshake, plus latency, count and hand-computed pins.
module tb_median_filter_stream;
    localparam int PW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
`ifdef MEDIAN_BORDER_REPLICATE_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, bypass, s_valid, s_ready, m_valid, m_ready, m_last, done;
    logic [PW-1:0] s_data, m_data;

    always #5 clk = ~clk;

    median_filter_stream #(.PIXEL_W(PW), .IMG_W(W), .IMG_H(H)) u_dut (
        .clk(clk), .reset(reset), .bypass(bypass),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .done(done)
    );

    int n_vec = 0;
    int n_bad = 0;
    int pix[N];
    int got[N];
    int ref_ramp[N];
    int in_cyc[N];
    int exp_q[$];
    int in_cnt = 0;
    int out_cnt = 0;
    int cyc = 0;
    bit lat_on = 1'b0;
    bit last_seen = 1'b0;

    function automatic void check(string name, int act, int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endfunction

    // Reference: bypass/border return the centre, otherwise the median of the clamped 3x3 neighbourhood.
    function automatic int model(int r, int c, bit byp);
        int v[9];
        int n;
        int rr, cc, t;
        n = 0;
        if (byp) return pix[r*W + c];
        if (!CLAMP && (r == 0 || r == H-1 || c == 0 || c == W-1)) return pix[r*W + c];
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                rr = (rr < 0) ? 0 : ((rr > H-1) ? H-1 : rr);
                cc = (cc < 0) ? 0 : ((cc > W-1) ? W-1 : cc);
                v[n] = pix[rr*W + cc];
                n++;
            end
        end
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
        end
        return v[4];
    endfunction

    // Compare process: every output handshake, plus done pulses and first-output latency.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                exp_q.delete();
                in_cnt = 0;
                out_cnt = 0;
                last_seen = 1'b0;
            end else begin
                if (done || last_seen) check("done_pulse", int'(done), int'(last_seen));
                last_seen = m_valid && m_ready && m_last;
                if (s_valid && s_ready) begin
                    if (in_cnt < N) in_cyc[in_cnt] = cyc;
                    in_cnt++;
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("extra_output_%0d", out_cnt), out_cnt, N - 1);
                    end else begin
                        check($sformatf("m_data_%0d", out_cnt), int'(m_data), exp_q[0]);
                        check($sformatf("m_last_%0d", out_cnt), int'(m_last), int'(out_cnt == N-1));
                        if (lat_on && out_cnt + W + 1 < N)
                            check($sformatf("latency_%0d", out_cnt), cyc - in_cyc[out_cnt + W + 1], 3);
                        void'(exp_q.pop_front());
                    end
                    if (out_cnt < N) got[out_cnt] = int'(m_data);
                    out_cnt++;
                end
            end
        end
    end

    task automatic run_frame(input int kind, input bit byp, input bit sv_rnd, input bit mr_rnd, input int abort_at);
        int i;
        int budget;
        bit fin;
        i = 0;
        budget = 0;
        fin = 1'b0;
        for (int k = 0; k < N; k++) begin
            case (kind)
                0: pix[k] = 8'h40;
                1: pix[k] = (k == 2*W + 3) ? 8'hFF : 0;
                2: pix[k] = (k == 3) ? 8'hFF : 0;
                3: pix[k] = ((k / W) + (k % W)) & 8'hFF;
                4: pix[k] = (k * 37) & 8'hFF;
                5: pix[k] = $urandom_range(0, 255);
                6: pix[k] = 8'h77;
                default: pix[k] = 8'h10;
            endcase
        end
        @(posedge clk); #1;
        in_cnt = 0;
        out_cnt = 0;
        lat_on = !mr_rnd;
        for (int k = 0; k < N; k++) exp_q.push_back(model(k / W, k % W, byp));
        while (!fin) begin
            if (i == abort_at) begin
                reset = 1'b1;
                s_valid = 1'b0;
                @(negedge clk);
                check("abort_s_ready", int'(s_ready), 0);
                check("abort_m_valid", int'(m_valid), 0);
                check("abort_m_last", int'(m_last), 0);
                check("abort_m_data", int'(m_data), 0);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            s_valid = (i < N) && (sv_rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            s_data  = PW'(pix[(i < N) ? i : 0]);
            bypass  = (i == 0) ? byp : !byp;
            m_ready = mr_rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) i++;
            if (done) fin = 1'b1;
            budget++;
            if (budget > 2000) begin
                n_vec++;
                n_bad++;
                $display("FAIL frame_timeout: actual no done after %0d cycles, required done", budget);
                fin = 1'b1;
            end
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        check("out_count", out_cnt, N);
        check("queue_left", exp_q.size(), 0);
        check("m_valid_after_done", int'(m_valid), 0);
        s_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        bypass = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_s_ready", int'(s_ready), 0);
        check("reset_m_valid", int'(m_valid), 0);
        check("reset_m_data", int'(m_data), 0);
        check("reset_m_last", int'(m_last), 0);
        check("reset_done", int'(done), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_s_ready", int'(s_ready), 1);

        run_frame(0, 1'b0, 1'b0, 1'b0, -1);
        check("pin_const_first", got[0], 8'h40);
        check("pin_const_last", got[N-1], 8'h40);

        run_frame(1, 1'b0, 1'b0, 1'b0, -1);
        check("pin_impulse_interior", got[2*W + 3], 0);

        run_frame(2, 1'b0, 1'b0, 1'b0, -1);
        check("pin_impulse_top", got[3], CLAMP ? 0 : 255);

        run_frame(3, 1'b0, 1'b0, 1'b0, -1);
        check("pin_ramp_r1c2", got[W + 2], 3);
        for (int k = 0; k < N; k++) ref_ramp[k] = got[k];

        run_frame(3, 1'b0, 1'b1, 1'b1, -1);
        for (int k = 0; k < N; k++) check($sformatf("ramp_stream_%0d", k), got[k], ref_ramp[k]);

        run_frame(4, 1'b0, 1'b1, 1'b0, -1);
        check("pin_mul37_r1c6", got[14], 46);
        check("pin_mul37_r0c6", got[6], CLAMP ? 185 : 222);

        run_frame(5, 1'b0, 1'b1, 1'b1, -1);

        run_frame(4, 1'b1, 1'b0, 1'b0, -1);
        check("pin_bypass_r1c6", got[14], 6);

        run_frame(6, 1'b0, 1'b0, 1'b0, 20);
        run_frame(7, 1'b0, 1'b1, 1'b1, -1);
        check("pin_after_abort_first", got[0], 8'h10);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
